// File: rtl/mem_if_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// FSM state codes, lane masks and the request legality check.
package mem_if_pkg;

    // Request size encodings
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD     = 3'd1;
    localparam state_t ST_RMW_RD = 3'd2;
    localparam state_t ST_WR     = 3'd3;
    localparam state_t ST_ERR    = 3'd4;
    localparam state_t ST_RESP   = 3'd5;

    // Right-aligned lane masks, shifted into place by the byte offset
    localparam logic [31:0] LANE_BYTE_MASK = 32'h0000_00ff;
    localparam logic [31:0] LANE_HALF_MASK = 32'h0000_ffff;

    // A request is rejected for a reserved size, a misaligned half/word or a
    // word index past the end of memory.
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr,
                                     input int unsigned depth);
        logic bad;
        bad = (size == SZ_RSVD) ||
              ((size == SZ_HALF) && addr[0]) ||
              ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        if ({2'b00, addr[31:2]} >= depth) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus from the datapath plus the strobes to the data memory.
// master: datapath and memory side; slave: the access controller.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemData;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, MemData,
        input  req_ready, resp_valid, resp_err, resp_rdata, MemRead, MemWrite, Address,
               WriteData
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, MemData,
        output req_ready, resp_valid, resp_err, resp_rdata, MemRead, MemWrite, Address,
               WriteData
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract and extend the addressed lane of a
// memory word for loads, and merge store data into the addressed lane(s).
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0] shamt;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;

    // Select the lane by size/offset, then extend or merge it
    always_comb begin
        shamt      = 5'd0;
        byte_lane  = 8'h00;
        half_lane  = 16'h0000;
        load_data  = rword;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                shamt      = {off, 3'b000};
                byte_lane  = rword[shamt +: 8];
                load_data  = {{24{sgn & byte_lane[7]}}, byte_lane};
                merge_data = (rword & ~(LANE_BYTE_MASK << shamt)) |
                             ((wdata & LANE_BYTE_MASK) << shamt);
            end
            SZ_HALF: begin
                shamt      = {off[1], 4'b0000};
                half_lane  = rword[shamt +: 16];
                load_data  = {{16{sgn & half_lane[15]}}, half_lane};
                merge_data = (rword & ~(LANE_HALF_MASK << shamt)) |
                             ((wdata & LANE_HALF_MASK) << shamt);
            end
            default: begin
                load_data  = rword;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the word-addressed data memory: accepts byte-addressed
// loads/stores, drives MemRead/MemWrite/Address/WriteData, and returns a
// single-cycle response. Sub-word stores use read-modify-write.
module mem_access_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH     = 500,
    parameter int unsigned READ_WAIT = 1
) (
    input logic             clk,
    input logic             reset,
    mem_access_ctrl_if.slave bus
);

    localparam int unsigned CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] wrdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [CW-1:0] cnt_q;

    logic        accept;
    logic        rd_last;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign rd_last = (cnt_q == CNT_LAST);

    mem_lane_align u_align (
        .size       (size_q),
        .sgn        (signed_q),
        .off        (off_q),
        .rword      (bus.MemData),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state: classify the request on accept, then walk read/write phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad(bus.req_size, bus.req_addr, DEPTH)) begin
                        state_d = ST_ERR;
                    end else if (!bus.req_write) begin
                        state_d = ST_RD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD:     if (rd_last) state_d = ST_RESP;
            ST_RMW_RD: if (rd_last) state_d = ST_WR;
            ST_WR:     state_d = ST_RESP;
            ST_ERR:    state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, request capture, read-wait counting and read-data sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0;
            addr_q   <= 32'h0;
            wrdata_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                off_q    <= bus.req_addr[1:0];
                wdata_q  <= bus.req_wdata;
                addr_q   <= {2'b00, bus.req_addr[31:2]};
                rdata_q  <= 32'h0;
                err_q    <= (state_d == ST_ERR);
                cnt_q    <= '0;
                if (state_d == ST_WR) begin
                    wrdata_q <= bus.req_wdata;
                end
            end
            if ((state_q == ST_RD) || (state_q == ST_RMW_RD)) begin
                if (rd_last) begin
                    // MemData is sampled on the last edge of the read phase
                    if (state_q == ST_RD) begin
                        rdata_q <= load_data;
                    end else begin
                        wrdata_q <= merge_data;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Strobes and response decoded from state so reset drops them at once
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.MemRead    = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign bus.MemWrite   = (state_q == ST_WR);
    assign bus.Address    = addr_q;
    assign bus.WriteData  = wrdata_q;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (READ_WAIT 1 and 3), word memories
// on each, and a byte-level reference model of the READ_WAIT=1 memory.
module tb_mem_access_ctrl;
    import mem_if_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus1 ();
    mem_access_ctrl_if bus3 ();

    mem_access_ctrl #(.DEPTH(500), .READ_WAIT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    mem_access_ctrl #(.DEPTH(500), .READ_WAIT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int n_checks = 0;
    int n_fail = 0;

    // Request drive, steered to one instance by sel
    logic sel = 1'b0;
    logic tb_valid = 1'b0, tb_write = 1'b0, tb_signed = 1'b0;
    logic [1:0] tb_size = 2'b00;
    logic [31:0] tb_addr = 32'h0, tb_wdata = 32'h0;

    assign bus1.req_valid = tb_valid & ~sel;
    assign bus3.req_valid = tb_valid & sel;
    assign bus1.req_write = tb_write;   assign bus3.req_write = tb_write;
    assign bus1.req_size = tb_size;     assign bus3.req_size = tb_size;
    assign bus1.req_signed = tb_signed; assign bus3.req_signed = tb_signed;
    assign bus1.req_addr = tb_addr;     assign bus3.req_addr = tb_addr;
    assign bus1.req_wdata = tb_wdata;   assign bus3.req_wdata = tb_wdata;

    logic o_ready, o_rv, o_err, o_rd, o_wr;
    logic [31:0] o_rdata;
    assign o_ready = sel ? bus3.req_ready : bus1.req_ready;
    assign o_rv    = sel ? bus3.resp_valid : bus1.resp_valid;
    assign o_err   = sel ? bus3.resp_err : bus1.resp_err;
    assign o_rdata = sel ? bus3.resp_rdata : bus1.resp_rdata;
    assign o_rd    = sel ? bus3.MemRead : bus1.MemRead;
    assign o_wr    = sel ? bus3.MemWrite : bus1.MemWrite;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9e37_79b9) ^ 32'h5a5a_0000;
    endfunction

    // Memories: level-sensitive read, write on the rising edge while MemWrite
    logic [31:0] mem1 [0:499];
    logic [31:0] mem3 [0:499];
    assign bus1.MemData = (bus1.Address < 500) ? mem1[bus1.Address] : 32'h0;
    assign bus3.MemData = (bus3.Address < 500) ? mem3[bus3.Address] : 32'h0;

    initial begin
        for (int i = 0; i < 500; i++) mem1[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus1.MemWrite && bus1.Address < 500) mem1[bus1.Address] = bus1.WriteData;
        end
    end

    initial begin
        for (int i = 0; i < 500; i++) mem3[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus3.MemWrite && bus3.Address < 500) mem3[bus3.Address] = bus3.WriteData;
        end
    end

    // Reference model: memory as a flat little-endian byte array
    logic [7:0] ref_bytes [0:1999];

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if ((a % size_bytes(sz)) != 0) return 1'b1;
        return (a / 4) >= 500;
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sg);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = size_bytes(sz);
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < size_bytes(sz); i++) ref_bytes[a+i] = 8'(d >> (8*i));
    endtask

    // Observations from the most recent transaction
    int obs_lat, obs_reads, obs_writes, obs_overlap, obs_ready_hi, obs_last_rd, obs_first_wr;
    logic [31:0] obs_rdata;
    logic obs_err;

    // Drive one request and record strobes/response until resp_valid (bounded)
    task automatic issue(input logic s, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        sel = s; tb_write = w; tb_size = sz; tb_signed = sg; tb_addr = a; tb_wdata = wd;
        for (int i = 0; i < 10 && !o_ready; i++) @(negedge clk);
        tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        obs_lat = 0; obs_reads = 0; obs_writes = 0; obs_overlap = 0; obs_ready_hi = 0;
        obs_last_rd = 0; obs_first_wr = 0; obs_rdata = 32'hx; obs_err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_rd) begin obs_reads++; obs_last_rd = k; end
            if (o_wr) begin obs_writes++; if (obs_first_wr == 0) obs_first_wr = k; end
            if (o_rd && o_wr) obs_overlap++;
            if (o_ready) obs_ready_hi++;
            if (o_rv) begin obs_lat = k; obs_rdata = o_rdata; obs_err = o_err; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus1.req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus1.req_ready); end
        n_checks++; if ({bus1.resp_valid, bus1.resp_err, bus1.MemRead, bus1.MemWrite} !== 4'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 0000",
            {bus1.resp_valid, bus1.resp_err, bus1.MemRead, bus1.MemWrite}); end
        n_checks++; if ({bus1.resp_rdata, bus1.Address, bus1.WriteData} !== 96'h0) begin n_fail++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h want 0", bus1.resp_rdata,
                     bus1.Address, bus1.WriteData); end
    endtask

    task automatic test_word();
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hdead_beef);
        model_store(32'h10, SZ_WORD, 32'hdead_beef);
        n_checks++; if (obs_lat !== 2) begin n_fail++;
            $display("FAIL word_store_lat: got %0d want 2", obs_lat); end
        n_checks++; if (obs_writes !== 1 || obs_reads !== 0) begin n_fail++;
            $display("FAIL word_store_strobes: rd %0d wr %0d want 0/1", obs_reads, obs_writes); end
        n_checks++; if (mem1[4] !== 32'hdead_beef) begin n_fail++;
            $display("FAIL word_store_mem: got %h want deadbeef", mem1[4]); end
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        n_checks++; if (obs_rdata !== 32'hdead_beef || obs_err !== 1'b0) begin n_fail++;
            $display("FAIL word_load: got %h err %b want deadbeef 0", obs_rdata, obs_err); end
        n_checks++; if (obs_lat !== 2 || obs_reads !== 1) begin n_fail++;
            $display("FAIL word_load_lat: lat %0d rd %0d want 2/1", obs_lat, obs_reads); end
    endtask

    task automatic test_subword_load();
        issue(1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
        n_checks++; if (obs_rdata !== 32'hffff_ffde) begin n_fail++;
            $display("FAIL byte_signed: got %h want ffffffde", obs_rdata); end
        issue(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
        n_checks++; if (obs_rdata !== 32'h0000_00de) begin n_fail++;
            $display("FAIL byte_unsigned: got %h want 000000de", obs_rdata); end
    endtask

    task automatic test_rmw();
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_1234);
        model_store(32'h12, SZ_HALF, 32'h1234);
        n_checks++; if (mem1[4] !== 32'h1234_beef) begin n_fail++;
            $display("FAIL half_store_mem: got %h want 1234beef", mem1[4]); end
        n_checks++; if (obs_lat !== 3 || obs_reads !== 1 || obs_writes !== 1) begin n_fail++;
            $display("FAIL half_store_seq: lat %0d rd %0d wr %0d want 3/1/1", obs_lat,
                     obs_reads, obs_writes); end
        n_checks++; if (obs_overlap !== 0 || !(obs_last_rd < obs_first_wr)) begin n_fail++;
            $display("FAIL half_store_order: overlap %0d last_rd %0d first_wr %0d", obs_overlap,
                     obs_last_rd, obs_first_wr); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs = '{32'h6, 32'h8, 32'h7d0};
        sizes = '{SZ_WORD, SZ_RSVD, SZ_WORD};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, sizes[i], 1'b0, addrs[i], 32'h0);
            n_checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 2) begin
                n_fail++; $display("FAIL err_case%0d: err %b rdata %h lat %0d want 1/0/2", i,
                                   obs_err, obs_rdata, obs_lat); end
            n_checks++; if (obs_reads !== 0 || obs_writes !== 0) begin n_fail++;
                $display("FAIL err_strobes%0d: rd %0d wr %0d want 0/0", i, obs_reads,
                         obs_writes); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, exp_rdata;
        logic [1:0] sz;
        logic w, sg, e;
        int exp_lat, exp_rd, exp_wr;
        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(3, 0));
            w = 1'($urandom);
            sg = 1'($urandom);
            wd = $urandom;
            if ($urandom_range(9, 0) == 0) a = 32'h0000_07c0 + 32'($urandom_range(400, 0));
            else a = 32'($urandom_range(63, 0));
            e = model_err(a, sz);
            exp_rdata = (e || w) ? 32'h0 : model_load(a, sz, sg);
            exp_lat = (!e && w && sz != SZ_WORD) ? 3 : 2;
            exp_rd = (!e && (!w || sz != SZ_WORD)) ? 1 : 0;
            exp_wr = (!e && w) ? 1 : 0;
            issue(1'b0, w, sz, sg, a, wd);
            if (!e && w) model_store(a, sz, wd);
            n_checks++; if (obs_err !== e || obs_rdata !== exp_rdata || obs_lat !== exp_lat) begin
                n_fail++; $display("FAIL rand%0d_resp a=%h sz=%0d w=%b: err %b rdata %h lat %0d want %b %h %0d",
                    t, a, sz, w, obs_err, obs_rdata, obs_lat, e, exp_rdata, exp_lat); end
            n_checks++; if (obs_reads !== exp_rd || obs_writes !== exp_wr || obs_overlap !== 0 ||
                            obs_ready_hi !== 0) begin n_fail++;
                $display("FAIL rand%0d_strobes: rd %0d wr %0d ov %0d rdy %0d want %0d %0d 0 0", t,
                         obs_reads, obs_writes, obs_overlap, obs_ready_hi, exp_rd, exp_wr); end
            if (!e) begin
                n_checks++; if (mem1[a/4] !== model_word(int'(a/4))) begin n_fail++;
                    $display("FAIL rand%0d_mem: word %0d got %h want %h", t, a/4, mem1[a/4],
                             model_word(int'(a/4))); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int hits;
        @(negedge clk);
        sel = 1'b0; tb_write = 1'b1; tb_size = SZ_WORD; tb_signed = 1'b0;
        tb_addr = 32'h24; tb_wdata = 32'hcafe_f00d; tb_valid = 1'b1;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus1.MemWrite !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_in_wr: MemWrite %b want 1", bus1.MemWrite); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus1.MemWrite !== 1'b0 || bus1.resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_drop: MemWrite %b resp_valid %b want 0 0", bus1.MemWrite,
                     bus1.resp_valid); end
        @(negedge clk) reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus1.resp_valid || bus1.MemWrite) hits++;
        end
        n_checks++; if (hits !== 0 || bus1.req_ready !== 1'b1) begin n_fail++;
            $display("FAIL rstmid_after: stray %0d ready %b want 0 1", hits, bus1.req_ready); end
        n_checks++; if (mem1[9] !== model_word(9)) begin n_fail++;
            $display("FAIL rstmid_mem: got %h want %h", mem1[9], model_word(9)); end
    endtask

    // Word 100 is never stored to through the READ_WAIT=1 instance
    task automatic test_wait3();
        logic [31:0] exp;
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h190, 32'h0);
        n_checks++; if (obs_reads !== 3 || obs_lat !== 4) begin n_fail++;
            $display("FAIL wait3_load_timing: rd %0d lat %0d want 3 4", obs_reads, obs_lat); end
        n_checks++; if (obs_rdata !== model_load(32'h190, SZ_WORD, 1'b0)) begin n_fail++;
            $display("FAIL wait3_load_data: got %h want %h", obs_rdata,
                     model_load(32'h190, SZ_WORD, 1'b0)); end
        issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h192, 32'h0);
        n_checks++; if (obs_rdata !== model_load(32'h192, SZ_HALF, 1'b1)) begin n_fail++;
            $display("FAIL wait3_half: got %h want %h", obs_rdata,
                     model_load(32'h192, SZ_HALF, 1'b1)); end
        issue(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h191, 32'h0000_00ab);
        exp = (init_word(100) & ~32'h0000_ff00) | 32'h0000_ab00;
        n_checks++; if (obs_lat !== 5 || obs_reads !== 3 || obs_writes !== 1 ||
                        !(obs_last_rd < obs_first_wr)) begin n_fail++;
            $display("FAIL wait3_rmw_seq: lat %0d rd %0d wr %0d want 5 3 1", obs_lat, obs_reads,
                     obs_writes); end
        n_checks++; if (mem3[100] !== exp) begin n_fail++;
            $display("FAIL wait3_rmw_mem: got %h want %h", mem3[100], exp); end
    endtask

    initial begin
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = 8'(init_word(i) >> (8*b));
        end
        test_reset();
        test_word();
        test_subword_load();
        test_rmw();
        test_errors();
        test_random();
        test_reset_mid();
        test_wait3();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
